ring_nic: RTL and testbench

RING_NIC -- requirements
Module: ring_nic

---
 rtl/cardinal_pkg.sv | 17 +
 rtl/nic_chan_buf.sv | 29 ++
 rtl/ring_nic.sv | 86 ++++++++
 tb/tb_ring_nic.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_pkg.sv
// Shared constants for the ring NIC: register map, data width, VC bit position.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cardinal_pkg;

    localparam int DATA_W = 64;

    // Processor-visible register map
    localparam logic [1:0] NIC_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

    // Virtual-channel bit inside a packet (bit 0 of a [0:W-1] word, i.e. the MSB)
    localparam int VC_BIT = 0;

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry packet buffer with full flag; load captures data and sets full, clear drops full.
// Latency: load/clear take effect at the clock edge they are sampled on.
// Backpressure: owner must only load when empty; the data word is kept after clear (stale).
module nic_chan_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [0:W-1] load_data,
    output logic [0:W-1] data,
    output logic         full
);

    // Buffer word and occupancy flag; load wins over clear (the owner never asserts both)
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ring_nic.sv
// Ring NIC: processor register interface bridging one input and one output packet buffer.
// Latency: reads are combinational; a captured or written packet is visible one cycle later.
// Backpressure: net_ri drops while the input buffer is full; net_so waits for net_ro and VC polarity.
module ring_nic #(
    parameter int DATA_W = cardinal_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:1]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity
);

    import cardinal_pkg::NIC_IN_BUF;
    import cardinal_pkg::NIC_IN_STAT;
    import cardinal_pkg::NIC_OUT_BUF;
    import cardinal_pkg::NIC_OUT_STAT;
    import cardinal_pkg::VC_BIT;

    logic              rd_en;
    logic              wr_en;
    logic              in_full;
    logic              out_full;
    logic [0:DATA_W-1] in_buf;
    logic [0:DATA_W-1] out_buf;
    logic              in_load;
    logic              in_clear;
    logic              out_load;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;

    // Both handshakes are held low during reset so nothing is accepted or half-sent
    assign net_ri = ~in_full & ~reset;
    assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity) & ~reset;
    assign net_do = out_buf;

    // Reading the input buffer pops it only if it actually holds a packet
    assign in_load  = net_si & net_ri;
    assign in_clear = rd_en & (addr == NIC_IN_BUF) & in_full;
    // out_full is still set during a send cycle, so a same-cycle write is dropped
    assign out_load = wr_en & (addr == NIC_OUT_BUF) & ~out_full;

    nic_chan_buf #(.W(DATA_W)) u_in_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (in_load),
        .clear     (in_clear),
        .load_data (net_di),
        .data      (in_buf),
        .full      (in_full)
    );

    nic_chan_buf #(.W(DATA_W)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .clear     (net_so),
        .load_data (d_in),
        .data      (out_buf),
        .full      (out_full)
    );

    // Combinational register read mux; status flags sit in the last (LSB) bit
    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (addr)
                NIC_IN_BUF:   d_out = in_buf;
                NIC_IN_STAT:  d_out[DATA_W-1] = in_full;
                NIC_OUT_STAT: d_out[DATA_W-1] = out_full;
                default:      d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_nic.sv
// Self-checking bench for ring_nic: directed vector table, reset sequence, randomized run vs queue model.
// Latency: inputs change 1 time unit after the rising edge, outputs sampled 2 units later.
// Backpressure: exercised through net_ri/net_ro/net_polarity in both directed and random stimulus.
module tb_ring_nic;

    localparam int DW = 64;

    logic          clk;
    logic          reset;
    logic [0:1]    addr;
    logic [0:DW-1] d_in;
    logic [0:DW-1] d_out;
    logic          nicEn;
    logic          nicWrEn;
    logic          net_si;
    logic          net_ri;
    logic [0:DW-1] net_di;
    logic          net_so;
    logic          net_ro;
    logic [0:DW-1] net_do;
    logic          net_polarity;

    int total = 0;
    int bad   = 0;

    ring_nic #(.DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        en;
        logic        wr;
        logic [63:0] din;
        logic        si;
        logic [63:0] di;
        logic        ro;
        logic        pol;
        logic [63:0] exp_dout;
        logic        exp_ri;
        logic        exp_so;
        logic [63:0] exp_do;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] a, input logic en, input logic wr,
                                input logic [63:0] din, input logic si, input logic [63:0] di,
                                input logic ro, input logic pol, input logic [63:0] e_dout,
                                input logic e_ri, input logic e_so, input logic [63:0] e_do);
        vec_t v;
        v.addr = a; v.en = en; v.wr = wr; v.din = din; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.exp_dout = e_dout; v.exp_ri = e_ri; v.exp_so = e_so;
        v.exp_do = e_do;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] a, input logic en, input logic wr,
                         input logic [63:0] din, input logic si, input logic [63:0] di,
                         input logic ro, input logic pol);
        reset = rst; addr = a; nicEn = en; nicWrEn = wr; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: packets held in queues (depth <= 1), plus last word seen per buffer
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] in_last;
    logic [63:0] out_last;

    localparam logic [63:0] PKT_A = 64'h8000_0000_0000_00AA;
    localparam logic [63:0] PKT_B = 64'h8000_0000_0000_0001;

    initial begin
        // Directed vectors: each row is one cycle, outputs checked before that cycle's edge
        tbl.push_back(mk(2'd0, 1, 0, 0,         0, 0,        0, 0, 0,        1, 0, 0));
        tbl.push_back(mk(2'd1, 1, 0, 0,         0, 0,        0, 0, 0,        1, 0, 0));
        tbl.push_back(mk(2'd3, 1, 0, 0,         0, 0,        0, 0, 0,        1, 0, 0));
        tbl.push_back(mk(2'd0, 0, 0, 0,         1, PKT_A,    0, 0, 0,        1, 0, 0));
        tbl.push_back(mk(2'd1, 1, 0, 0,         0, 0,        0, 0, 1,        0, 0, 0));
        tbl.push_back(mk(2'd0, 1, 0, 0,         0, 0,        0, 0, PKT_A,    0, 0, 0));
        tbl.push_back(mk(2'd0, 0, 0, 0,         0, 0,        0, 0, 0,        1, 0, 0));
        tbl.push_back(mk(2'd0, 1, 0, 0,         0, 0,        0, 0, PKT_A,    1, 0, 0));
        tbl.push_back(mk(2'd2, 1, 1, 64'h1234,  0, 0,        1, 0, 0,        1, 0, 0));
        tbl.push_back(mk(2'd0, 0, 0, 0,         0, 0,        1, 0, 0,        1, 1, 64'h1234));
        tbl.push_back(mk(2'd3, 1, 0, 0,         0, 0,        1, 0, 0,        1, 0, 64'h1234));
        tbl.push_back(mk(2'd2, 1, 1, PKT_B,     0, 0,        1, 0, 0,        1, 0, 64'h1234));
        tbl.push_back(mk(2'd0, 0, 0, 0,         0, 0,        1, 0, 0,        1, 0, PKT_B));
        tbl.push_back(mk(2'd3, 1, 0, 0,         0, 0,        1, 0, 1,        1, 0, PKT_B));
        tbl.push_back(mk(2'd0, 0, 0, 0,         0, 0,        1, 1, 0,        1, 1, PKT_B));
        tbl.push_back(mk(2'd3, 1, 0, 0,         0, 0,        0, 0, 0,        1, 0, PKT_B));
        tbl.push_back(mk(2'd2, 1, 1, 64'h1111,  0, 0,        0, 0, 0,        1, 0, PKT_B));
        tbl.push_back(mk(2'd2, 1, 1, 64'h5555,  0, 0,        0, 0, 0,        1, 0, 64'h1111));
        tbl.push_back(mk(2'd3, 1, 0, 0,         0, 0,        0, 0, 1,        1, 0, 64'h1111));
        tbl.push_back(mk(2'd0, 0, 0, 0,         1, 64'hBEEF, 0, 0, 0,        1, 0, 64'h1111));
        tbl.push_back(mk(2'd0, 0, 0, 0,         1, 64'hDEAD, 0, 0, 0,        0, 0, 64'h1111));
        tbl.push_back(mk(2'd0, 1, 0, 0,         0, 0,        0, 0, 64'hBEEF, 0, 0, 64'h1111));
        tbl.push_back(mk(2'd2, 1, 1, 64'h2222,  0, 0,        1, 0, 0,        1, 1, 64'h1111));
        tbl.push_back(mk(2'd3, 1, 0, 0,         0, 0,        0, 0, 0,        1, 0, 64'h1111));
        tbl.push_back(mk(2'd0, 1, 1, 64'hFFFF,  0, 0,        0, 0, 0,        1, 0, 64'h1111));
        tbl.push_back(mk(2'd1, 1, 0, 0,         0, 0,        0, 0, 0,        1, 0, 64'h1111));
        tbl.push_back(mk(2'd0, 1, 0, 0,         0, 0,        0, 0, 64'hBEEF, 1, 0, 64'h1111));
        tbl.push_back(mk(2'd2, 1, 1, 64'h3333,  1, 64'h77,   0, 0, 0,        1, 0, 64'h1111));
        tbl.push_back(mk(2'd1, 1, 0, 0,         0, 0,        1, 0, 1,        0, 1, 64'h3333));
        tbl.push_back(mk(2'd0, 1, 0, 0,         0, 0,        0, 0, 64'h77,   0, 0, 64'h3333));
        tbl.push_back(mk(2'd3, 1, 0, 0,         0, 0,        0, 0, 0,        1, 0, 64'h3333));

        // Reset: handshakes must be low while reset is held
        drive(1, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        next_cycle();
        next_cycle();
        #2;
        chk("rst_ri_low", {63'b0, net_ri}, 64'd0);
        chk("rst_so_low", {63'b0, net_so}, 64'd0);
        next_cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(0, tbl[i].addr, tbl[i].en, tbl[i].wr, tbl[i].din, tbl[i].si, tbl[i].di,
                  tbl[i].ro, tbl[i].pol);
            #2;
            chk($sformatf("vec%0d_dout", i), d_out, tbl[i].exp_dout);
            chk($sformatf("vec%0d_ri", i), {63'b0, net_ri}, {63'b0, tbl[i].exp_ri});
            chk($sformatf("vec%0d_so", i), {63'b0, net_so}, {63'b0, tbl[i].exp_so});
            chk($sformatf("vec%0d_do", i), net_do, tbl[i].exp_do);
            next_cycle();
        end

        // Reset with both buffers full: nothing may be sent and both buffers are emptied
        drive(0, 2'd2, 1, 1, 64'h4444, 1, 64'hCAFE, 0, 0);
        next_cycle();
        drive(0, 2'd3, 1, 0, 0, 0, 0, 0, 0);
        #2;
        chk("full_both_out", d_out, 64'd1);
        chk("full_both_ri", {63'b0, net_ri}, 64'd0);
        next_cycle();
        drive(1, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        chk("midrst_so", {63'b0, net_so}, 64'd0);
        chk("midrst_ri", {63'b0, net_ri}, 64'd0);
        next_cycle();
        drive(0, 2'd1, 1, 0, 0, 0, 0, 1, 0);
        #2;
        chk("postrst_in_stat", d_out, 64'd0);
        chk("postrst_so", {63'b0, net_so}, 64'd0);
        chk("postrst_do", net_do, 64'd0);
        chk("postrst_ri", {63'b0, net_ri}, 64'd1);
        next_cycle();
        drive(0, 2'd3, 1, 0, 0, 0, 0, 1, 0);
        #2;
        chk("postrst_out_stat", d_out, 64'd0);
        next_cycle();
        drive(0, 2'd0, 1, 0, 0, 0, 0, 1, 0);
        #2;
        chk("postrst_in_buf", d_out, 64'd0);
        chk("postrst_so2", {63'b0, net_so}, 64'd0);
        next_cycle();

        // Randomized traffic against the queue model
        in_q.delete();
        out_q.delete();
        in_last  = '0;
        out_last = '0;
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_en, r_wr, r_si, r_ro, r_pol;
            logic [1:0]  r_addr;
            logic [63:0] r_din, r_di, e_dout, e_do;
            logic        e_ri, e_so;
            r_rst  = ($urandom_range(0, 49) == 0);
            r_en   = $urandom_range(0, 1) == 1;
            r_wr   = $urandom_range(0, 1) == 1;
            r_addr = 2'($urandom_range(0, 3));
            r_din  = {$urandom, $urandom};
            r_si   = $urandom_range(0, 9) < 4;
            r_di   = {$urandom, $urandom};
            r_ro   = $urandom_range(0, 9) < 6;
            r_pol  = $urandom_range(0, 1) == 1;
            drive(r_rst, r_addr, r_en, r_wr, r_din, r_si, r_di, r_ro, r_pol);
            #2;
            e_ri = !r_rst && (in_q.size() == 0);
            e_so = !r_rst && (out_q.size() != 0) && r_ro && (out_last[63] == r_pol);
            e_do = out_last;
            e_dout = '0;
            if (r_en && !r_wr) begin
                case (r_addr)
                    2'd0:    e_dout = in_last;
                    2'd1:    e_dout = {63'b0, in_q.size() != 0};
                    2'd3:    e_dout = {63'b0, out_q.size() != 0};
                    default: e_dout = '0;
                endcase
            end
            chk($sformatf("rnd%0d_dout", n), d_out, e_dout);
            chk($sformatf("rnd%0d_ri", n), {63'b0, net_ri}, {63'b0, e_ri});
            chk($sformatf("rnd%0d_so", n), {63'b0, net_so}, {63'b0, e_so});
            chk($sformatf("rnd%0d_do", n), net_do, e_do);
            if (r_rst) begin
                in_q.delete();
                out_q.delete();
                in_last  = '0;
                out_last = '0;
            end else begin
                if (r_si && e_ri) begin
                    in_q.push_back(r_di);
                    in_last = r_di;
                end else if (r_en && !r_wr && r_addr == 2'd0 && in_q.size() != 0) begin
                    void'(in_q.pop_front());
                end
                if (e_so) begin
                    void'(out_q.pop_front());
                end else if (r_en && r_wr && r_addr == 2'd2 && out_q.size() == 0) begin
                    out_q.push_back(r_din);
                    out_last = r_din;
                end
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
